// File: rtl/lcd_sw_spi_master.sv
// lcd_sw_spi_master: mode-3 SPI engine for the front-panel LCD/switch bus.
// Sends one DATA_WIDTH-bit word MSB-first per accepted start, captures the
// returned word, and steers chip select to the LCD or the switch register.
module lcd_sw_spi_master #(
  parameter int DATA_WIDTH = 24,
  parameter int CLK_DIV    = 100,
  parameter int CS_SETUP   = 50,
  parameter int CS_HOLD    = 50
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_spi_start,
  input  logic [DATA_WIDTH-1:0] i_mosi_data,
  input  logic                  i_lcd_sw_cs,
  output logic [DATA_WIDTH-1:0] o_miso_data,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_spi_sclk,
  output logic                  o_spi_mosi,
  input  logic                  i_spi_miso,
  output logic                  o_lcd_cs,
  output logic                  o_sw_cs_n
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT,
    HOLD,
    DONE
  } state_t;

  localparam logic [10:0] SETUP_LAST = 11'(CS_SETUP - 1);
  localparam logic [10:0] DIV_LAST   = 11'(CLK_DIV - 1);
  localparam logic [10:0] HOLD_LAST  = 11'(CS_HOLD - 1);
  localparam logic [4:0]  BIT_LAST   = 5'(DATA_WIDTH - 1);

  state_t                state_q, state_d;
  logic [10:0]           cnt_q, cnt_d;
  logic [4:0]            bit_q, bit_d;
  logic                  sclk_q, sclk_d;
  logic                  sel_q, sel_d;
  logic [DATA_WIDTH-1:0] tx_q, tx_d;
  logic [DATA_WIDTH-1:0] rx_q, rx_d;
  logic [DATA_WIDTH-1:0] miso_q, miso_d;
  logic                  sync1_q, sync2_q;
  logic                  cs_active;

  // Two-flop synchronizer for the asynchronous MISO line.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= i_spi_miso;
      sync2_q <= sync1_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b1;
      sel_q   <= 1'b0;
      tx_q    <= '0;
      rx_q    <= '0;
      miso_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sclk_q  <= sclk_d;
      sel_q   <= sel_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      miso_q  <= miso_d;
    end
  end

  // Next-state logic: phase timing, SCLK generation, shifting and capture.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sclk_d  = sclk_q;
    sel_d   = sel_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    miso_d  = miso_q;
    unique case (state_q)
      IDLE: begin
        if (i_spi_start) begin
          state_d = SETUP;
          tx_d    = i_mosi_data;
          sel_d   = i_lcd_sw_cs;
          bit_d   = '0;
          cnt_d   = '0;
        end
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = SHIFT;
          cnt_d   = '0;
          sclk_d  = 1'b0;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      SHIFT: begin
        if (cnt_q == DIV_LAST) begin
          cnt_d = '0;
          if (!sclk_q) begin
            sclk_d = 1'b1;
          end else begin
            // Last cycle of the high half: capture, then fall and shift
            // unless this was the final bit (SCLK then stays high).
            rx_d = {rx_q[DATA_WIDTH-2:0], sync2_q};
            if (bit_q == BIT_LAST) begin
              state_d = HOLD;
            end else begin
              bit_d  = bit_q + 5'd1;
              sclk_d = 1'b0;
              tx_d   = {tx_q[DATA_WIDTH-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          // Loaded on entry to DONE so the word appears with o_done.
          state_d = DONE;
          cnt_d   = '0;
          miso_d  = rx_q;
        end else begin
          cnt_d = cnt_q + 11'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode from registered state.
  always_comb begin
    cs_active   = (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
    o_busy      = (state_q != IDLE);
    o_done      = (state_q == DONE);
    o_lcd_cs    = cs_active & ~sel_q;
    o_sw_cs_n   = ~(cs_active & sel_q);
    o_spi_sclk  = sclk_q;
    o_spi_mosi  = tx_q[DATA_WIDTH-1];
    o_miso_data = miso_q;
  end

endmodule

// File: tb/tb_lcd_sw_spi_master.sv
// Bench for lcd_sw_spi_master: one default-timing instance and one fast
// instance (CLK_DIV=4, CS_SETUP=1, CS_HOLD=1), checked against a
// transaction-level model of frame timing, bit order and select steering.
module tb_lcd_sw_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n  [2];
  logic        start  [2];
  logic [23:0] mdata  [2];
  logic        selin  [2];
  logic [23:0] rdata  [2];
  logic        busy   [2];
  logic        done   [2];
  logic        sclk   [2];
  logic        mosi   [2];
  logic        miso   [2];
  logic        lcd    [2];
  logic        swn    [2];

  int cdiv   [2];
  int ssetup [2];
  int shold  [2];
  logic [23:0] exp_miso [2];

  int ncmp  = 0;
  int nfail = 0;

  lcd_sw_spi_master #(.DATA_WIDTH(24), .CLK_DIV(100), .CS_SETUP(50), .CS_HOLD(50)) u_dut0 (
    .i_clk(clk), .i_rst(rst_n[0]), .i_spi_start(start[0]), .i_mosi_data(mdata[0]),
    .i_lcd_sw_cs(selin[0]), .o_miso_data(rdata[0]), .o_busy(busy[0]), .o_done(done[0]),
    .o_spi_sclk(sclk[0]), .o_spi_mosi(mosi[0]), .i_spi_miso(miso[0]),
    .o_lcd_cs(lcd[0]), .o_sw_cs_n(swn[0]));

  lcd_sw_spi_master #(.DATA_WIDTH(24), .CLK_DIV(4), .CS_SETUP(1), .CS_HOLD(1)) u_dut1 (
    .i_clk(clk), .i_rst(rst_n[1]), .i_spi_start(start[1]), .i_mosi_data(mdata[1]),
    .i_lcd_sw_cs(selin[1]), .o_miso_data(rdata[1]), .o_busy(busy[1]), .o_done(done[1]),
    .o_spi_sclk(sclk[1]), .o_spi_mosi(mosi[1]), .i_spi_miso(miso[1]),
    .o_lcd_cs(lcd[1]), .o_sw_cs_n(swn[1]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ncmp++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input int d, input string tag);
    check(tag, {26'd0, sclk[d], mosi[d], lcd[d], swn[d], busy[d], done[d]}, 32'b100100);
    check({tag, "_miso_data"}, {8'd0, rdata[d]}, 32'd0);
  endtask

  // One full transfer on instance d. MISO is either looped back from MOSI
  // or driven from pat, one bit per SCLK falling edge. extra=1 injects
  // ignored starts mid-frame and on the DONE cycle. abort_fall>=0 asserts
  // reset a few cycles into the bit with that index and ends the transfer.
  task automatic xfer(input int d, input logic [23:0] data, input logic s,
                      input bit loop, input logic [23:0] pat, input bit extra,
                      input int abort_fall, input string tag);
    int lat, cyc, csc, falls, badsel, badbusy, badhold, badper, last_fall;
    logic [23:0] got, expr;
    logic psclk;
    lat = 1 + ssetup[d] + 48 * cdiv[d] + shold[d];
    expr = loop ? data : pat;
    csc = 0; falls = 0; badsel = 0; badbusy = 0; badhold = 0; badper = 0;
    last_fall = 0; got = '0; psclk = 1'b1;
    mdata[d] = data;
    selin[d] = s;
    start[d] = 1'b1;
    miso[d]  = loop ? mosi[d] : pat[23];
    @(posedge clk);
    @(negedge clk);
    start[d] = 1'b0;
    cyc = 1;
    while (!done[d] && cyc < lat + 50) begin
      if (s == 1'b0 ? lcd[d] : !swn[d]) csc++;
      if (s == 1'b0 ? !swn[d] : lcd[d]) badsel++;
      if (!busy[d]) badbusy++;
      if (rdata[d] !== exp_miso[d]) badhold++;
      if (psclk && !sclk[d]) begin
        if (falls > 0 && cyc - last_fall != 2 * cdiv[d]) badper++;
        last_fall = cyc;
        if (!loop && falls < 24) miso[d] = pat[23 - falls];
        falls++;
      end
      if (!psclk && sclk[d]) got = {got[22:0], mosi[d]};
      if (loop) miso[d] = mosi[d];
      psclk = sclk[d];
      if (abort_fall >= 0 && falls == abort_fall + 1 && cyc == last_fall + 3) begin
        rst_n[d] = 1'b0;
        #1;
        check_reset_outputs(d, {tag, "_abort"});
        exp_miso[d] = '0;
        @(negedge clk);
        check({tag, "_abort_nodone"}, {31'd0, done[d]}, 32'd0);
        return;
      end
      if (extra && cyc == lat / 2) begin
        mdata[d] = ~data;
        selin[d] = ~s;
        start[d] = 1'b1;
      end else begin
        start[d] = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    check({tag, "_latency"}, cyc, lat);
    check({tag, "_done"}, {31'd0, done[d]}, 32'd1);
    check({tag, "_cs_off_at_done"}, {30'd0, lcd[d], swn[d]}, 32'b01);
    check({tag, "_miso_data"}, {8'd0, rdata[d]}, {8'd0, expr});
    check({tag, "_mosi_bits"}, {8'd0, got}, {8'd0, data});
    check({tag, "_cs_cycles"}, csc, lat - 1);
    check({tag, "_wrong_sel"}, badsel, 0);
    check({tag, "_busy_gap"}, badbusy, 0);
    check({tag, "_early_update"}, badhold, 0);
    check({tag, "_sclk_falls"}, falls, 24);
    check({tag, "_sclk_period"}, badper, 0);
    exp_miso[d] = expr;
    if (extra) begin
      mdata[d] = ~data;
      start[d] = 1'b1;
    end
    @(negedge clk);
    start[d] = 1'b0;
    check({tag, "_idle_after"}, {30'd0, busy[d], done[d]}, 32'd0);
    check({tag, "_miso_held"}, {8'd0, rdata[d]}, {8'd0, expr});
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cdiv   = '{100, 4};
    ssetup = '{50, 1};
    shold  = '{50, 1};
    for (int i = 0; i < 2; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      mdata[i] = '0;
      selin[i] = 1'b0;
      miso[i]  = 1'b0;
      exp_miso[i] = '0;
    end
    #12;
    check_reset_outputs(0, "reset0");
    check_reset_outputs(1, "reset1");
    @(negedge clk);
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    @(negedge clk);

    // Default-timing instance: directed frames.
    xfer(0, 24'hF85040, 1'b0, 1'b0, 24'h5A1E37, 1'b0, -1, "lcd_f85040");
    xfer(0, 24'hA5C33C, 1'b1, 1'b1, 24'h000000, 1'b0, -1, "sw_loop_a5c33c");
    xfer(0, 24'h3C0F81, 1'b1, 1'b0, 24'h0000FE, 1'b0, -1, "sw_pat_0000fe");
    xfer(0, 24'h81F00D, 1'b1, 1'b0, 24'h000000, 1'b1, -1, "miso_low_extra");
    xfer(0, 24'h6B2D94, 1'b0, 1'b1, 24'h000000, 1'b0, -1, "start_after_done");
    xfer(0, 24'hC3E1F0, 1'b0, 1'b1, 24'h000000, 1'b0, 10, "reset_bit10");
    repeat (3) @(negedge clk);
    rst_n[0] = 1'b1;
    @(negedge clk);
    check_reset_outputs(0, "post_release");
    xfer(0, 24'hFA0040, 1'b0, 1'b1, 24'h000000, 1'b0, -1, "after_reset_fa0040");

    // Fast instance: randomized frames, loopback or driven MISO.
    for (int n = 0; n < 20; n++) begin
      logic [23:0] rd, rp;
      logic rs;
      bit rl;
      rd = 24'($urandom);
      rp = 24'($urandom);
      rs = 1'($urandom_range(0, 1));
      rl = 1'($urandom_range(0, 1));
      xfer(1, rd, rs, rl, rp, (n % 5) == 4, -1, "fast_rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
